// File: rtl/adc_pll_supervisor.sv
// adc_pll_supervisor: refclk-domain sequencer that pulses the ADC PLL reset, qualifies lock and releases dn_rst.
// Define ADC_PLL_LOSS_COUNT_EN to add the saturating loss_cnt output that counts RUN lock losses.
module adc_pll_supervisor #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int HOLD_CYCLES   = 32,
    parameter int MAX_RETRIES   = 3,
    localparam int RW = $clog2(MAX_RETRIES + 1)
) (
    input  logic          refclk,
    input  logic          rst,
    input  logic          pll_locked,
    input  logic          relock_req,
    output logic          pll_rst,
    output logic          dn_rst,
    output logic          ready,
    output logic          fault,
    output logic [RW-1:0] retry_cnt,
    output logic [2:0]    state
`ifdef ADC_PLL_LOSS_COUNT_EN
    ,
    output logic [15:0]   loss_cnt
`endif
);
    localparam int PMAX = (RST_CYCLES > STABLE_CYCLES)
                        ? ((RST_CYCLES > HOLD_CYCLES) ? RST_CYCLES : HOLD_CYCLES)
                        : ((STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES);
    localparam int PW = $clog2(PMAX) + 1;
    localparam int TW = $clog2(LOCK_TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_PLLRST    = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_HOLD      = 3'd3,
        S_RUN       = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [PW-1:0] r_phase;
    logic [TW-1:0] r_tmo;
    logic [RW-1:0] r_retry;
    logic [RW-1:0] w_retry_inc;
    logic          w_tmo_hit;
    logic          w_tmo_exp;
    logic          w_relock;
    logic          r_lock_m;
    logic          r_lock_s;

    // pll_locked is asynchronous; plain two-flop synchronizer, deliberately not reset.
    always_ff @(posedge refclk) begin
        r_lock_m <= pll_locked;
        r_lock_s <= r_lock_m;
    end

    assign w_retry_inc = r_retry + RW'(1);
    assign w_tmo_hit   = (r_tmo == TW'(LOCK_TIMEOUT - 1));
    assign w_relock    = relock_req && (r_state != S_PLLRST);

    always_comb begin
        w_next    = r_state;
        w_tmo_exp = 1'b0;
        if (w_relock) begin
            w_next = S_PLLRST;
        end else begin
            case (r_state)
                S_PLLRST: begin
                    if (r_phase == PW'(RST_CYCLES - 1)) w_next = S_WAIT_LOCK;
                end
                S_WAIT_LOCK, S_STABLE: begin
                    if (w_tmo_hit) begin
                        w_tmo_exp = 1'b1;
                        w_next    = (w_retry_inc == RW'(MAX_RETRIES)) ? S_FAULT : S_PLLRST;
                    end else if (r_state == S_WAIT_LOCK) begin
                        if (r_lock_s) w_next = S_STABLE;
                    end else if (!r_lock_s) begin
                        w_next = S_WAIT_LOCK;
                    end else if (r_phase == PW'(STABLE_CYCLES - 1)) begin
                        w_next = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!r_lock_s)                              w_next = S_PLLRST;
                    else if (r_phase == PW'(HOLD_CYCLES - 1))   w_next = S_RUN;
                end
                S_RUN: begin
                    if (!r_lock_s) w_next = S_PLLRST;
                end
                S_FAULT: w_next = S_FAULT;
                default: w_next = S_PLLRST;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state <= S_PLLRST;
            r_phase <= '0;
            r_tmo   <= '0;
            r_retry <= '0;
            pll_rst <= 1'b1;
            dn_rst  <= 1'b1;
            ready   <= 1'b0;
            fault   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state || !(w_next inside {S_PLLRST, S_STABLE, S_HOLD}))
                r_phase <= '0;
            else
                r_phase <= r_phase + PW'(1);
            // Not cleared on STABLE->WAIT_LOCK so a flapping lock still times out.
            r_tmo <= (r_state == S_WAIT_LOCK || r_state == S_STABLE) ? r_tmo + TW'(1) : '0;
            if (w_relock)
                r_retry <= '0;
            else if (w_tmo_exp)
                r_retry <= w_retry_inc;
            else if (w_next == S_RUN && r_state != S_RUN)
                r_retry <= '0;
            pll_rst <= (w_next == S_PLLRST) || (w_next == S_FAULT);
            dn_rst  <= (w_next != S_RUN);
            ready   <= (w_next == S_RUN);
            fault   <= (w_next == S_FAULT);
        end
    end

    assign retry_cnt = r_retry;
    assign state     = r_state;

`ifdef ADC_PLL_LOSS_COUNT_EN
    logic        w_loss_evt;
    logic [15:0] r_loss;

    assign w_loss_evt = (r_state == S_RUN) && !relock_req && !r_lock_s;

    always_ff @(posedge refclk) begin
        if (rst)
            r_loss <= '0;
        else if (w_loss_evt && r_loss != 16'hFFFF)
            r_loss <= r_loss + 16'd1;
    end

    assign loss_cnt = r_loss;
`endif

endmodule
